// File: rtl/bip_fetch_control.sv
// BIP fetch/decode control: sequences FETCH -> WAIT -> EXEC, absorbs the program-memory
// read latency, decodes the latched instruction into one-cycle datapath strobes.
module bip_fetch_control #(
  parameter int ADDR_WIDTH   = 11,
  parameter int DATA_WIDTH   = 16,
  parameter int OPCODE_WIDTH = 5,
  parameter int MEM_LATENCY  = 2,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [DATA_WIDTH-1:0]              i_data,
  output logic [ADDR_WIDTH-1:0]              o_addr,
  output logic [DATA_WIDTH-OPCODE_WIDTH-1:0] o_operand,
  output logic                               o_wr_acc,
  output logic [1:0]                         o_sel_a,
  output logic                               o_sel_b,
  output logic                               o_op,
  output logic                               o_wr_ram,
  output logic                               o_rd_ram,
  output logic                               o_valid,
  output logic                               o_halt,
  output logic [COUNT_WIDTH-1:0]             o_clk_count
);

  localparam int OPER_W = DATA_WIDTH - OPCODE_WIDTH;
  localparam int WCNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_LATENCY - 1);

  localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_STO  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDV  = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = OPCODE_WIDTH'(7);

  if (OPER_W != ADDR_WIDTH) begin : g_bad_width
    $error("operand field width must equal ADDR_WIDTH");
  end
  if (MEM_LATENCY < 1 || MEM_LATENCY > 2) begin : g_bad_latency
    $error("MEM_LATENCY must be 1 or 2");
  end

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_EXEC, S_HALT} state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [WCNT_W-1:0]         wait_cnt;
  logic [ADDR_WIDTH-1:0]     pc;
  logic [DATA_WIDTH-1:0]     ir;
  logic [COUNT_WIDTH-1:0]    clk_count;
  logic [OPCODE_WIDTH-1:0]   opcode;
  logic                      wait_last;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

  assign opcode    = ir[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign wait_last = (state == S_WAIT) && (wait_cnt == WCNT_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_FETCH: state_nxt = S_WAIT;
      S_WAIT:  if (wait_last) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = (opcode == OP_HLT) ? S_HALT : S_FETCH;
      S_HALT:  state_nxt = S_HALT;
    endcase
  end

  // IR captures the word at the edge closing the last WAIT cycle, when memory data is aligned
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wait_cnt  <= '0;
      pc        <= '0;
      ir        <= '0;
      clk_count <= '0;
    end else begin
      wait_cnt <= (state == S_WAIT) ? wait_cnt + WCNT_W'(1) : '0;
      if (wait_last) ir <= i_data;
      if (state == S_EXEC && opcode != OP_HLT) pc <= pc + ADDR_WIDTH'(1);
      if (state != S_HALT) clk_count <= sat_inc(clk_count);
    end
  end

  always_comb begin
    o_wr_acc = 1'b0;
    o_sel_a  = 2'd0;
    o_sel_b  = 1'b0;
    o_op     = 1'b0;
    o_wr_ram = 1'b0;
    o_rd_ram = 1'b0;
    o_valid  = 1'b0;
    if (state == S_EXEC) begin
      o_valid = 1'b1;
      case (opcode)
        OP_HLT:  o_valid = 1'b0;
        OP_STO:  o_wr_ram = 1'b1;
        OP_LDV:  begin o_wr_acc = 1'b1; o_sel_a = 2'd1; end
        OP_LDI:  begin o_wr_acc = 1'b1; o_rd_ram = 1'b1; end
        OP_ADD:  begin o_wr_acc = 1'b1; o_rd_ram = 1'b1; o_sel_a = 2'd2; end
        OP_ADDI: begin o_wr_acc = 1'b1; o_sel_a = 2'd2; o_sel_b = 1'b1; end
        OP_SUB:  begin o_wr_acc = 1'b1; o_rd_ram = 1'b1; o_sel_a = 2'd2; o_op = 1'b1; end
        OP_SUBI: begin o_wr_acc = 1'b1; o_sel_a = 2'd2; o_sel_b = 1'b1; o_op = 1'b1; end
        default: ;
      endcase
    end
  end

  assign o_addr      = pc;
  assign o_operand   = ir[OPER_W-1:0];
  assign o_halt      = (state == S_HALT);
  assign o_clk_count = clk_count;

endmodule

// File: tb/tb_bip_fetch_control.sv
// Bench for bip_fetch_control: latency-2 and latency-1 instances, each fed by a
// pipelined program-memory model, with an EXEC-strobe scoreboard per instance.
module tb_bip_fetch_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [15:0] data_a, data_b;
  logic [10:0] addr_a, addr_b, oper_a, oper_b;
  logic        wacc_a, wacc_b, selb_a, selb_b, op_a, op_b;
  logic [1:0]  sela_a, sela_b;
  logic        wram_a, wram_b, rram_a, rram_b, vld_a, vld_b, halt_a, halt_b;
  logic [31:0] cnt_a, cnt_b;

  bip_fetch_control #(.MEM_LATENCY(2)) dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_data(data_a), .o_addr(addr_a), .o_operand(oper_a),
    .o_wr_acc(wacc_a), .o_sel_a(sela_a), .o_sel_b(selb_a), .o_op(op_a), .o_wr_ram(wram_a),
    .o_rd_ram(rram_a), .o_valid(vld_a), .o_halt(halt_a), .o_clk_count(cnt_a));

  bip_fetch_control #(.MEM_LATENCY(1)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_data(data_b), .o_addr(addr_b), .o_operand(oper_b),
    .o_wr_acc(wacc_b), .o_sel_a(sela_b), .o_sel_b(selb_b), .o_op(op_b), .o_wr_ram(wram_b),
    .o_rd_ram(rram_b), .o_valid(vld_b), .o_halt(halt_b), .o_clk_count(cnt_b));

  // Program memories: A returns data two edges after the address, B one edge after
  logic [15:0] mem_a [0:2047];
  logic [15:0] mem_b [0:2047];
  logic [15:0] pa1, pa2, pb1;
  always @(posedge clk) begin
    pa1 <= mem_a[addr_a];
    pa2 <= pa1;
    pb1 <= mem_b[addr_b];
  end
  assign data_a = pa2;
  assign data_b = pb1;

  logic [63:0] q_a[$];
  logic [63:0] q_b[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic [31:0] cnt, input logic [10:0] pc,
      input logic [10:0] oper, input logic wa, input logic [1:0] sa, input logic sb,
      input logic op, input logic wr, input logic rd);
    return {3'b000, cnt, pc, oper, wa, sa, sb, op, wr, rd};
  endfunction

  function automatic logic [63:0] exp_of(input logic [15:0] w, input logic [10:0] pc,
      input logic [31:0] cnt);
    logic wa, sb, op, wr, rd;
    logic [1:0] sa;
    wa = 1'b0; sb = 1'b0; op = 1'b0; wr = 1'b0; rd = 1'b0; sa = 2'd0;
    case (w[15:11])
      5'd1: wr = 1'b1;
      5'd2: begin wa = 1'b1; sa = 2'd1; end
      5'd3: begin wa = 1'b1; rd = 1'b1; end
      5'd4: begin wa = 1'b1; rd = 1'b1; sa = 2'd2; end
      5'd5: begin wa = 1'b1; sa = 2'd2; sb = 1'b1; end
      5'd6: begin wa = 1'b1; rd = 1'b1; sa = 2'd2; op = 1'b1; end
      5'd7: begin wa = 1'b1; sa = 2'd2; sb = 1'b1; op = 1'b1; end
      default: ;
    endcase
    return pack(cnt, pc, w[10:0], wa, sa, sb, op, wr, rd);
  endfunction

  always @(negedge clk) begin
    if (vld_a) begin
      chk("q_a_nonempty", q_a.size() != 0, 1);
      if (q_a.size() != 0)
        chk("exec_a", pack(cnt_a, addr_a, oper_a, wacc_a, sela_a, selb_a, op_a, wram_a, rram_a),
            q_a.pop_front());
    end else begin
      chk("idle_strobes_a", {wacc_a, sela_a, selb_a, op_a, wram_a, rram_a}, 0);
    end
    if (vld_b) begin
      chk("q_b_nonempty", q_b.size() != 0, 1);
      if (q_b.size() != 0)
        chk("exec_b", pack(cnt_b, addr_b, oper_b, wacc_b, sela_b, selb_b, op_b, wram_b, rram_b),
            q_b.pop_front());
    end else begin
      chk("idle_strobes_b", {wacc_b, sela_b, selb_b, op_b, wram_b, rram_b}, 0);
    end
  end

  // Push the expected EXEC records for n instructions, stopping at the first HLT
  task automatic expect_prog(input int which, input int n, input int per);
    logic [15:0] w;
    for (int k = 0; k < n; k++) begin
      w = (which != 0) ? mem_b[k % 2048] : mem_a[k % 2048];
      if (w[15:11] == 5'd0) break;
      if (which != 0) q_b.push_back(exp_of(w, 11'(k % 2048), 32'(per * (k + 1) - 1)));
      else            q_a.push_back(exp_of(w, 11'(k % 2048), 32'(per * (k + 1) - 1)));
    end
  endtask

  task automatic clear_mem_a();
    for (int i = 0; i < 2048; i++) mem_a[i] = 16'h0000;
  endtask

  task automatic reset_a_hold();
    @(negedge clk);
    rst_a = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_addr_a", addr_a, 0);
    chk("rst_cnt_a", cnt_a, 0);
    chk("rst_halt_a", halt_a, 0);
    chk("rst_valid_a", vld_a, 0);
    chk("rst_q_a_empty", q_a.size(), 0);
  endtask

  task automatic wait_halt(input int which, input int maxc);
    int c;
    c = 0;
    while (((which != 0) ? halt_b : halt_a) !== 1'b1 && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk((which != 0) ? "halt_reached_b" : "halt_reached_a", (which != 0) ? halt_b : halt_a, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst_a = 1'b0;
    rst_b = 1'b0;
    for (int i = 0; i < 2048; i++) begin mem_a[i] = 16'h0000; mem_b[i] = 16'h0000; end
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;

    // LDV 5, ADDI 3, STO 7, HLT at latency 2
    mem_a[0] = {5'd2, 11'd5}; mem_a[1] = {5'd5, 11'd3};
    mem_a[2] = {5'd1, 11'd7}; mem_a[3] = 16'h0000;
    reset_a_hold();
    expect_prog(0, 4, 4);
    rst_a = 1'b0;
    wait_halt(0, 100);
    chk("halt_cnt_a", cnt_a, 16);
    chk("halt_addr_a", addr_a, 3);
    chk("halt_q_a_empty", q_a.size(), 0);
    repeat (5) @(negedge clk);
    chk("frozen_cnt_a", cnt_a, 16);
    chk("frozen_addr_a", addr_a, 3);
    chk("frozen_halt_a", halt_a, 1);

    // Same program at latency 1
    mem_b[0] = {5'd2, 11'd5}; mem_b[1] = {5'd5, 11'd3};
    mem_b[2] = {5'd1, 11'd7}; mem_b[3] = 16'h0000;
    repeat (2) @(negedge clk);
    expect_prog(1, 4, 3);
    rst_b = 1'b0;
    wait_halt(1, 100);
    chk("halt_cnt_b", cnt_b, 12);
    chk("halt_addr_b", addr_b, 3);
    chk("halt_q_b_empty", q_b.size(), 0);

    // LDI 9, ADD 9, SUB 9, SUBI 1, HLT
    clear_mem_a();
    mem_a[0] = {5'd3, 11'd9}; mem_a[1] = {5'd4, 11'd9};
    mem_a[2] = {5'd6, 11'd9}; mem_a[3] = {5'd7, 11'd1};
    reset_a_hold();
    expect_prog(0, 5, 4);
    rst_a = 1'b0;
    wait_halt(0, 100);
    chk("alu_halt_cnt_a", cnt_a, 20);
    chk("alu_halt_addr_a", addr_a, 4);

    // Opcode 11111 is a NOP, then HLT
    clear_mem_a();
    mem_a[0] = 16'hFFFF;
    reset_a_hold();
    expect_prog(0, 2, 4);
    rst_a = 1'b0;
    wait_halt(0, 100);
    chk("nop_halt_addr_a", addr_a, 1);
    chk("nop_halt_cnt_a", cnt_a, 8);

    // 2048 NOPs, no HLT: PC wraps and execution continues
    for (int i = 0; i < 2048; i++) mem_a[i] = {5'(8 + i % 24), 11'(i)};
    reset_a_hold();
    expect_prog(0, 2052, 4);
    rst_a = 1'b0;
    c = 0;
    while (q_a.size() != 0 && c < 9000) begin @(negedge clk); c++; end
    chk("wrap_drain_a", q_a.size(), 0);
    chk("wrap_no_halt_a", halt_a, 0);

    // Reset asserted during WAIT of the third instruction
    clear_mem_a();
    mem_a[0] = {5'd2, 11'd1}; mem_a[1] = {5'd2, 11'd2};
    mem_a[2] = {5'd2, 11'd3}; mem_a[3] = 16'h0000;
    reset_a_hold();
    expect_prog(0, 2, 4);
    rst_a = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("pre_rst_addr_a", addr_a, 2);
    rst_a = 1'b1;
    #1;
    chk("async_rst_addr_a", addr_a, 0);
    chk("async_rst_cnt_a", cnt_a, 0);
    chk("async_rst_oper_a", oper_a, 0);
    chk("async_rst_valid_a", vld_a, 0);
    chk("async_rst_q_a_empty", q_a.size(), 0);
    @(negedge clk);
    expect_prog(0, 4, 4);
    rst_a = 1'b0;
    wait_halt(0, 100);
    chk("restart_halt_cnt_a", cnt_a, 16);
    chk("restart_halt_addr_a", addr_a, 3);
    chk("restart_q_a_empty", q_a.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bip_fetch_control.md
Name: bip_fetch_control

Overview:
- Fetch/decode control unit of the BIP processor, directly upstream of the program memory.
- Holds the PC and drives the program memory address.
- Absorbs the memory's fixed read latency, then latches the returned instruction and decodes it into one-cycle datapath control strobes (accumulator/ALU/data-RAM).
- Stops on HLT and exposes a cycle counter for the debug/UART readout.

Parameters:
- ADDR_WIDTH, 11, PC / program-memory address width (2048 words).
- DATA_WIDTH, 16, instruction width; opcode = [15:11], operand = [10:0].
- OPCODE_WIDTH, 5, opcode field width; DATA_WIDTH-OPCODE_WIDTH must equal ADDR_WIDTH.
- MEM_LATENCY, 2, program-memory read latency in cycles; legal values 1 (LOW_LATENCY) or 2 (HIGH_PERFORMANCE).
- COUNT_WIDTH, 32, width of the executed-cycle counter.

Ports:
- i_clk, in, 1, clock; all state changes on rising edge.
- i_rst, in, 1, reset, asynchronous, active-high.
- i_data, in, DATA_WIDTH, instruction word from program memory.
- o_addr, out, ADDR_WIDTH, program-memory address (= PC register).
- o_operand, out, DATA_WIDTH-OPCODE_WIDTH, operand field of the latched instruction.
- o_wr_acc, out, 1, accumulator write enable.
- o_sel_a, out, 2, accumulator mux: 0 = data RAM, 1 = immediate, 2 = ALU.
- o_sel_b, out, 1, ALU B mux: 0 = data RAM, 1 = immediate.
- o_op, out, 1, ALU op: 0 = add, 1 = sub.
- o_wr_ram, out, 1, data-RAM write enable.
- o_rd_ram, out, 1, data-RAM read enable.
- o_valid, out, 1, one-cycle strobe per executed instruction.
- o_halt, out, 1, sticky halt flag.
- o_clk_count, out, COUNT_WIDTH, cycles elapsed since reset release, frozen at halt.

Behaviour:
- Reset (async, immediate): state = FETCH; PC, IR, o_clk_count = 0; all strobes, o_sel_a, o_sel_b, o_op, o_halt = 0.
  - Reset mid-instruction discards any in-flight memory data.
- FSM states:
  - FETCH: lasts 1 cycle; o_addr = PC is sampled by memory at the end of the cycle. Next state is WAIT.
  - WAIT: lasts exactly MEM_LATENCY cycles, counted by an internal counter. IR <= i_data at the edge ending the last WAIT cycle. Next state is EXEC.
  - EXEC: lasts 1 cycle; strobes are decoded from IR.
    - Opcode HLT: next state HALT, PC unchanged.
    - Any other opcode: PC <= PC+1 and next state FETCH.
  - HALT: terminal until reset. o_halt = 1, all strobes 0, PC frozen, counter frozen.
- Throughput: one instruction per 2+MEM_LATENCY cycles (4 at default).
- Strobes (o_wr_acc, o_wr_ram, o_rd_ram, o_valid) are nonzero only in EXEC. Outside EXEC, o_sel_a = 0, o_sel_b = 0, o_op = 0.
- o_operand = IR[10:0] at all times.
- Decode table in EXEC; o_valid = 1 for every opcode except HLT; unlisted fields = 0:
  - 00000 HLT: all 0, o_valid = 0.
  - 00001 STO: wr_ram.
  - 00010 LDV: wr_acc, sel_a = 1.
  - 00011 LDI: rd_ram, wr_acc, sel_a = 0.
  - 00100 ADD: rd_ram, wr_acc, sel_a = 2, sel_b = 0, op = 0.
  - 00101 ADDI: wr_acc, sel_a = 2, sel_b = 1, op = 0.
  - 00110 SUB: rd_ram, wr_acc, sel_a = 2, sel_b = 0, op = 1.
  - 00111 SUBI: wr_acc, sel_a = 2, sel_b = 1, op = 1.
  - 01000..11111: NOP; only o_valid = 1, PC increments.
- PC wrap: PC = 2^ADDR_WIDTH-1 increments to 0, with no flag.
- o_clk_count:
  - Increments every cycle after reset release while not in HALT, including the EXEC cycle of HLT.
  - Saturates at all-ones.
  - First increment occurs at the first edge after reset deassertion.
- o_halt is registered: rises at the edge ending HLT's EXEC cycle.

Test Plan:
- Reset then program LDV 5, ADDI 3, STO 7, HLT (MEM_LATENCY=2) -> o_addr steps 0,1,2,3 every 4 cycles. EXEC strobes:
  - LDV: wr_acc=1, sel_a=1, operand=5.
  - ADDI: wr_acc=1, sel_a=2, sel_b=1, op=0, operand=3.
  - STO: wr_ram=1, operand=7.
  - HLT: o_halt=1, o_clk_count=16 and frozen, o_addr stays 3.
- Same program with MEM_LATENCY=1 -> 3 cycles per instruction; IR holds the correct word, proving the latency alignment; o_clk_count=12 at halt.
- LDI 9, ADD 9, SUB 9, SUBI 1 -> exact rd_ram/sel/op patterns per the decode table; o_valid high exactly once per instruction.
- Opcode 11111 at addr 0, HLT at addr 1 -> o_valid=1 with all writes 0, PC advances to 1, then halt.
- 2048 NOPs preloaded (no HLT) -> after addr 2047, o_addr wraps to 0 and execution continues.
- Assert i_rst during WAIT of the 3rd instruction -> outputs zero immediately; after release, fetch restarts at addr 0 and o_clk_count restarts from 0.
